// File: rtl/synth_pkg.sv
// Shared constants for the tone sequencer: FSM encoding, waveform codes,
// note increment table and the 16-step sequence ROM.
package synth_pkg;

  typedef enum logic [1:0] {StIdle, StNote, StGap} state_e;

  localparam logic [1:0] WaveSquare  = 2'd0;
  localparam logic [1:0] WaveSaw     = 2'd1;
  localparam logic [1:0] WaveTri     = 2'd2;
  localparam logic [1:0] WaveSilence = 2'd3;

  localparam logic [3:0] NoteRest = 4'd0;
  localparam logic [7:0] EnvFull  = 8'hFF;

  // Phase increment per sample at ~47.6 kHz: round(f * 65536 / 47619).
  function automatic logic [15:0] note_inc(input logic [3:0] code);
    logic [15:0] inc;
    case (code)
      4'd1:    inc = 16'h0168; // C4
      4'd2:    inc = 16'h017D;
      4'd3:    inc = 16'h0194; // D4
      4'd4:    inc = 16'h01AC;
      4'd5:    inc = 16'h01C6; // E4
      4'd6:    inc = 16'h01E1; // F4
      4'd7:    inc = 16'h01FD;
      4'd8:    inc = 16'h021B; // G4
      4'd9:    inc = 16'h023C;
      4'd10:   inc = 16'h025E; // A4
      4'd11:   inc = 16'h0282;
      4'd12:   inc = 16'h02A8; // B4
      4'd13:   inc = 16'h02D0; // C5
      4'd14:   inc = 16'h0328; // D5
      4'd15:   inc = 16'h038B; // E5
      default: inc = 16'h0000; // rest
    endcase
    return inc;
  endfunction

  function automatic logic [3:0] seq_note(input logic [3:0] step);
    logic [3:0] code;
    case (step)
      4'd0:    code = 4'd10;
      4'd1:    code = 4'd12;
      4'd2:    code = 4'd13;
      4'd3:    code = NoteRest;
      4'd4:    code = 4'd14;
      4'd5:    code = 4'd13;
      4'd6:    code = 4'd12;
      4'd7:    code = 4'd10;
      4'd8:    code = 4'd8;
      4'd9:    code = 4'd10;
      4'd10:   code = 4'd12;
      4'd11:   code = 4'd8;
      4'd12:   code = 4'd6;
      4'd13:   code = 4'd5;
      4'd14:   code = 4'd3;
      default: code = 4'd1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/synth_osc.sv
// 16-bit phase accumulator with square/saw/triangle/silence waveform select.
module synth_osc
  import synth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inc,
  input  logic        advance,
  input  logic        clear,
  input  logic [1:0]  wave_sel,
  output logic [7:0]  wave
);

  logic [15:0] r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 16'h0000;
    end else if (clear) begin
      r_phase <= 16'h0000;
    end else if (advance) begin
      r_phase <= r_phase + inc;
    end
  end

  always_comb begin
    wave = 8'h00;
    case (wave_sel)
      WaveSquare: wave = r_phase[15] ? 8'hFF : 8'h00;
      WaveSaw:    wave = r_phase[15:8];
      WaveTri:    wave = r_phase[15] ? ~r_phase[14:7] : r_phase[14:7];
      default:    wave = 8'h00;
    endcase
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a 16-step note sequence as 8-bit unsigned samples, one per sample tick,
// with a per-step linear-decay envelope and a silent gap at the end of each step.
module tone_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = 21,
  parameter int unsigned STEP_SAMPLES = 6000,
  parameter int unsigned GAP_SAMPLES  = 600,
  parameter int unsigned ENV_DIV      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] wave_sel,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic [3:0] step_idx
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CNT_W = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam int unsigned PRE_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  localparam logic [DIV_W-1:0] DivLast  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(STEP_SAMPLES - 1);
  localparam logic [CNT_W-1:0] NoteLast = CNT_W'(STEP_SAMPLES - GAP_SAMPLES - 1);
  localparam logic [PRE_W-1:0] PreLast  = PRE_W'(ENV_DIV - 1);

  state_e           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic [7:0]       r_env, w_env_nxt;
  logic [3:0]       r_step, w_step_nxt;
  logic [7:0]       r_sample, w_sample_nxt;
  logic             r_valid, w_valid_nxt;

  logic        w_tick, w_step_end, w_note_end;
  logic [3:0]  w_step_inc;
  logic [7:0]  w_wave;
  logic [15:0] w_product;
  logic        w_osc_clear, w_osc_advance;

  assign w_tick     = (r_state != StIdle) && (r_div == DivLast);
  assign w_step_end = w_tick && (r_cnt == CntLast);
  assign w_note_end = w_tick && (r_state == StNote) && (r_cnt == NoteLast);
  assign w_step_inc = r_step + 4'd1;
  assign w_product  = 16'(w_wave) * 16'(r_env);

  assign w_osc_clear   = !enable || (r_state == StIdle) || w_step_end;
  assign w_osc_advance = enable && w_tick && (r_state == StNote);

  synth_osc u_osc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (note_inc(seq_note(r_step))),
    .advance  (w_osc_advance),
    .clear    (w_osc_clear),
    .wave_sel (wave_sel),
    .wave     (w_wave)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Step end is checked before note end so a zero-length gap rolls straight on.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle:  w_state_nxt = StNote;
        StNote: begin
          if (w_step_end)      w_state_nxt = StNote;
          else if (w_note_end) w_state_nxt = StGap;
        end
        StGap:   if (w_step_end) w_state_nxt = StNote;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_comb begin
    w_div_nxt    = r_div;
    w_cnt_nxt    = r_cnt;
    w_pre_nxt    = r_pre;
    w_env_nxt    = r_env;
    w_step_nxt   = r_step;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    if (!enable) begin
      w_div_nxt    = '0;
      w_cnt_nxt    = '0;
      w_pre_nxt    = '0;
      w_step_nxt   = 4'd0;
      w_sample_nxt = 8'h00;
    end else if (r_state == StIdle) begin
      w_div_nxt  = '0;
      w_cnt_nxt  = '0;
      w_pre_nxt  = '0;
      w_step_nxt = 4'd0;
      w_env_nxt  = (seq_note(4'd0) == NoteRest) ? 8'h00 : EnvFull;
    end else begin
      w_div_nxt   = w_tick ? '0 : r_div + 1'b1;
      w_valid_nxt = w_tick;
      if (w_tick) begin
        w_cnt_nxt = w_step_end ? '0 : r_cnt + 1'b1;
        if (r_state == StNote) begin
          w_sample_nxt = w_product[15:8];
          if (r_pre == PreLast) begin
            w_pre_nxt = '0;
            w_env_nxt = (r_env == 8'h00) ? 8'h00 : r_env - 8'd1;
          end else begin
            w_pre_nxt = r_pre + 1'b1;
          end
        end else begin
          w_sample_nxt = 8'h00;
        end
        if (w_step_end) begin
          w_step_nxt = w_step_inc;
          w_pre_nxt  = '0;
          w_env_nxt  = (seq_note(w_step_inc) == NoteRest) ? 8'h00 : EnvFull;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_cnt    <= '0;
      r_pre    <= '0;
      r_env    <= 8'h00;
      r_step   <= 4'd0;
      r_sample <= 8'h00;
      r_valid  <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pre    <= w_pre_nxt;
      r_env    <= w_env_nxt;
      r_step   <= w_step_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign step_idx     = r_step;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: three instances with different parameters,
// scoreboard queues filled at stimulus time and drained on sample_valid.
module tb_tone_sequencer;

  typedef struct packed {
    logic [7:0] val;
    logic       care;
    logic [3:0] step;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       def_en = 1'b0, env_en = 1'b0, stp_en = 1'b0;
  logic [1:0] def_wave = 2'd1, env_wave = 2'd0, stp_wave = 2'd1;
  logic [7:0] def_sample, env_sample, stp_sample;
  logic       def_valid, env_valid, stp_valid;
  logic [3:0] def_step, env_step, stp_step;

  logic [7:0] def_q[$];
  logic [7:0] env_q[$];
  exp_t       stp_q[$];
  logic       stp_mon = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  tone_sequencer u_def (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (def_en),
    .wave_sel     (def_wave),
    .sample_out   (def_sample),
    .sample_valid (def_valid),
    .step_idx     (def_step)
  );

  tone_sequencer #(
    .SAMPLE_DIV   (4),
    .STEP_SAMPLES (6000),
    .GAP_SAMPLES  (600),
    .ENV_DIV      (1)
  ) u_env (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (env_en),
    .wave_sel     (env_wave),
    .sample_out   (env_sample),
    .sample_valid (env_valid),
    .step_idx     (env_step)
  );

  tone_sequencer #(
    .SAMPLE_DIV   (4),
    .STEP_SAMPLES (8),
    .GAP_SAMPLES  (2),
    .ENV_DIV      (24)
  ) u_stp (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (stp_en),
    .wave_sel     (stp_wave),
    .sample_out   (stp_sample),
    .sample_valid (stp_valid),
    .step_idx     (stp_step)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step test, saw wave, env 255 at step start: step 0 opens 0,1,3; gaps and rest are 0.
  task automatic push_stp(input int n0, input int n1);
    exp_t e;
    int k, s;
    for (int n = n0; n <= n1; n++) begin
      k = n % 8;
      s = (n / 8) % 16;
      e.step = 4'((k == 7) ? (s + 1) % 16 : s);
      e.care = (k >= 6) || (s == 3) || (s == 0 && k < 3);
      e.val  = (k >= 6 || s == 3 || k == 0) ? 8'd0 : (k == 1) ? 8'd1 : 8'd3;
      stp_q.push_back(e);
    end
  endtask

  function automatic int qsize(input int w);
    if (w == 0) return def_q.size();
    if (w == 1) return env_q.size();
    return stp_q.size();
  endfunction

  task automatic wait_drain(input int w, input int budget, input string tag);
    int n = 0;
    while (qsize(w) != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 16'(qsize(w)), 16'd0);
  endtask

  task automatic wait_def_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!def_valid && n < 200);
  endtask

  always @(negedge clk) begin
    if (def_valid && def_q.size() != 0) chk("def_sample", 16'(def_sample), 16'(def_q.pop_front()));
  end

  always @(negedge clk) begin
    if (env_valid && env_q.size() != 0) chk("env_sample", 16'(env_sample), 16'(env_q.pop_front()));
  end

  always @(negedge clk) begin
    exp_t e;
    if (stp_mon && stp_valid) begin
      if (stp_q.size() == 0) begin
        chk("stp_unexpected_valid", 16'(stp_valid), 16'd0);
      end else begin
        e = stp_q.pop_front();
        chk("stp_step_idx", 16'(stp_step), 16'(e.step));
        if (e.care) chk("stp_sample", 16'(stp_sample), 16'(e.val));
      end
    end
  end

  initial begin
    int n;
    int ph, env, v;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_def_sample", 16'(def_sample), 16'd0);
    chk("rst_def_valid", 16'(def_valid), 16'd0);
    chk("rst_def_step", 16'(def_step), 16'd0);
    chk("rst_env_sample", 16'(env_sample), 16'd0);
    chk("rst_env_valid", 16'(env_valid), 16'd0);
    chk("rst_stp_step", 16'(stp_step), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_def_valid", 16'(def_valid), 16'd0);

    // Tick cadence and oscillator on defaults (saw, A4, env 255 for first samples).
    def_q.push_back(8'h00);
    def_q.push_back(8'h01);
    def_q.push_back(8'h03);
    def_q.push_back(8'h06);
    def_en = 1'b1;
    @(posedge clk);
    wait_def_valid(n);
    chk("first_valid_latency", 16'(n), 16'd21);
    for (int p = 0; p < 2; p++) begin
      @(posedge clk);
      #1;
      chk("valid_width", 16'(def_valid), 16'd0);
      wait_def_valid(n);
      chk("tick_period", 16'(n + 1), 16'd21);
    end
    wait_drain(0, 200, "def_drain");
    @(posedge clk);
    #1;
    def_en = 1'b0;
    @(posedge clk);
    #1;
    chk("def_stop_sample", 16'(def_sample), 16'd0);
    chk("def_stop_valid", 16'(def_valid), 16'd0);

    // Envelope: square, ENV_DIV=1, step 0 A4 (inc 606).
    for (int i = 0; i < 300; i++) begin
      ph  = (i * 606) % 65536;
      env = (i < 255) ? 255 - i : 0;
      v   = ((ph / 32768) == 1) ? (255 * env) / 256 : 0;
      env_q.push_back(8'(v));
    end
    @(posedge clk);
    #1;
    env_en = 1'b1;
    wait_drain(1, 1400, "env_drain");
    env_en = 1'b0;

    // Steps: play into step 5 NOTE, then stop.
    push_stp(0, 44);
    stp_mon = 1'b1;
    @(posedge clk);
    #1;
    stp_en = 1'b1;
    wait_drain(2, 240, "stp_run1_drain");
    chk("stp_step_before_stop", 16'(stp_step), 16'd5);
    chk("stp_note_nonzero", 16'(stp_sample != 8'h00), 16'd1);
    @(posedge clk);
    #1;
    stp_en = 1'b0;
    @(posedge clk);
    #1;
    chk("stop_sample", 16'(stp_sample), 16'd0);
    chk("stop_step", 16'(stp_step), 16'd0);
    chk("stop_valid", 16'(stp_valid), 16'd0);
    repeat (20) @(posedge clk);

    // Restart from step 0 and run through the 15 -> 0 wrap.
    push_stp(0, 135);
    #1;
    stp_en = 1'b1;
    wait_drain(2, 600, "stp_run2_drain");
    @(posedge clk);
    #1;
    stp_en = 1'b0;
    repeat (3) @(posedge clk);
    stp_mon = 1'b0;

    // Async reset mid-NOTE, then restart from IDLE with enable still high.
    #1;
    stp_en = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(stp_valid && stp_sample != 8'h00 && stp_step != 4'd0) && n < 400);
    chk("rst_setup_reached", 16'(n < 400), 16'd1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_sample", 16'(stp_sample), 16'd0);
    chk("async_rst_valid", 16'(stp_valid), 16'd0);
    chk("async_rst_step", 16'(stp_step), 16'd0);
    push_stp(0, 9);
    stp_mon = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(2, 120, "stp_restart_drain");
    @(posedge clk);
    #1;
    stp_en = 1'b0;
    repeat (3) @(posedge clk);
    stp_mon = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Audio sample source for the audio PMOD path. It plays a fixed 16-step note sequence from a package ROM using a 16-bit phase-accumulator oscillator with a selectable waveform and a linear-decay envelope. It emits one unsigned 8-bit sample per sample tick, which feeds directly into the PDM modulator's `pdm_in`.

## Interface
- `SAMPLE_DIV`, default 21: clock cycles per sample tick (≈47.6 kHz at 1 MHz).
- `STEP_SAMPLES`, default 6000: sample ticks per sequence step.
- `GAP_SAMPLES`, default 600: silent ticks at the end of each step. Must be less than `STEP_SAMPLES`.
- `ENV_DIV`, default 24: sample ticks per envelope decrement.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: level; 1 = play, 0 = stop and rewind.
- `wave_sel`  in  2: 0 square, 1 saw, 2 triangle, 3 silence.
- `sample_out`  out  8: unsigned sample; hold value between ticks.
- `sample_valid`  out  1: one-cycle pulse when `sample_out` updates.
- `step_idx`  out  4: current sequence step.

## Operation
- **Reset values:** `sample_out`=0, `sample_valid`=0, `step_idx`=0, state IDLE, phase=0, env=0, divider=0, sample count=0, envelope prescaler=0.
- **States:** IDLE, NOTE, GAP.
  - IDLE → NOTE when `enable`=1 is sampled. On entry: `step_idx`=0, phase=0, divider=0, and env=255, or env=0 if the step-0 note is a rest.
  - NOTE → GAP after `STEP_SAMPLES-GAP_SAMPLES` ticks in the step.
  - GAP → NOTE at step end. At that point `step_idx`+1 (15 wraps to 0), phase=0, env reloads (255, or 0 for a rest), and the envelope prescaler resets.
  - Any state → IDLE on the next edge when `enable`=0. This also sets `sample_out`=0, `step_idx`=0, and phase=0.
- **Divider:** counts 0..`SAMPLE_DIV-1` while not IDLE. The tick is the cycle where divider equals `SAMPLE_DIV-1`, after which the divider returns to 0.
- **On each tick in NOTE:**
  - `sample_out` ← (wave × env) >> 8, computed from the *current* phase and env (8×8 multiply, 16-bit product, upper byte kept).
  - phase ← phase + inc[note], mod 2^16.
  - Every `ENV_DIV`th tick, env ← env−1, saturating at 0.
- **On each tick in GAP:** `sample_out` ← 0; phase and env frozen.
- **Waveforms** (p = phase):
  - square: 0xFF if p[15]=1, else 0x00.
  - saw: p[15:8].
  - triangle: ~p[14:7] if p[15]=1, else p[14:7].
  - silence: 0x00.
  - `wave_sel` is sampled on each tick; a change takes effect at the next sample.
- **Note codes** (4-bit): 0 = rest (increment 0, env 0); 1..12 = C4..B4 chromatic; 13..15 = C5, D5, E5.
  - inc = round(f × 65536 / 47619). A4 (code 10) = 0x025E.
- **Sequence ROM:** 16 note codes. Step 0 = A4; step 3 = rest.

## Timing
- `sample_out` and `sample_valid` are registered at the tick edge; they are valid in the cycle after the tick.
- `sample_valid` is high for exactly one cycle per tick and is never high in IDLE.
- The first `sample_valid` occurs `SAMPLE_DIV` cycles after the edge that samples `enable`=1.
- `step_idx` changes on the same edge as the last GAP sample of a step.
- Asserting `rst_n` low mid-operation clears all outputs immediately, without waiting for a clock edge.
- A simultaneous tick and `enable` drop: IDLE wins; no `sample_valid` is produced.

## Structure
- Shared package `synth_pkg` holds:
  - note increment table (16 × 16-bit);
  - sequence ROM (16 × 4-bit);
  - wave_sel encodings;
  - state encoding (IDLE/NOTE/GAP).
- Sub-module `synth_osc` holds the phase accumulator plus waveform mux. It has inputs inc, advance, clear, and wave_sel, and output wave[7:0].
- The top level holds the FSM, divider, step counter, envelope, and output multiply.

## Test plan
- **Async reset:** pulse `rst_n` low between edges mid-NOTE → `sample_out`=0, `sample_valid`=0, `step_idx`=0 before the next edge; the design restarts from IDLE.
- **Tick cadence** (defaults): raise `enable` → the first `sample_valid` arrives 21 cycles after the sampling edge, then a pulse every 21 cycles, each one cycle wide.
- **Oscillator** (saw, large `ENV_DIV`, step 0 A4): `sample_out` for samples 0, 1, 2 = 0x00, 0x01, 0x03, i.e. (0x02·255)>>8 and (0x04·255)>>8. Phase after sample 2 = 0x071A.
- **Envelope** (`ENV_DIV`=1, square, long step): the first high-half sample equals (255×env)>>8. Env reaches 0 after 255 ticks and `sample_out` stays 0 thereafter.
- **Steps** (`STEP_SAMPLES`=8, `GAP_SAMPLES`=2, `SAMPLE_DIV`=4):
  - samples 6–7 of every step are 0;
  - step 3 (rest) outputs 0 for all 8 samples;
  - `step_idx` goes 15→0 after 128 ticks.
- **Stop/restart:** drop `enable` mid-NOTE of step 5 → next cycle `sample_out`=0 and `step_idx`=0, with no further `sample_valid`. Re-enable → playback restarts at step 0 with phase 0.
